// File: rtl/rbb_arb_pkg.sv
// Shared types and sizing helpers for the result-batch-buffer write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rbb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } arbState_t;

    // lineCnt needs one bit beyond the line index to hold NUM_LINES itself
    localparam int LINE_CNT_EXTRA = 1;

    function automatic int numLines(input int addrWidth);
        return 1 << addrWidth;
    endfunction

endpackage

// File: rtl/rbb_wr_arbiter_rr_pick.sv
// Round-robin first-one finder: first set req bit strictly after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from the farthest candidate inward so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbb_wr_arbiter.sv
// Round-robin host write arbiter over NUM_RBB result batch buffers, one whole batch per grant.
// Latency: ack combinational, write request registered one cycle later; one line per 2 cycles.
// Backpressure: wr_req_almfull holds ISSUE with no ack. Optional stats under RBB_ARB_STATS_EN.
module rbb_wr_arbiter
    import rbb_arb_pkg::*;
#(
    parameter int NUM_RBB         = 4,
    parameter int RBB_ADDR_WIDTH  = 4,
    parameter int RBB_DATA_WIDTH  = 512,
    parameter int HOST_ADDR_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_RBB-1:0]                  rbb_req_valid,
    input  logic [NUM_RBB*RBB_ADDR_WIDTH-1:0]   rbb_req_line_idx,
    input  logic [NUM_RBB*RBB_DATA_WIDTH-1:0]   rbb_rd_dout,
    output logic [NUM_RBB-1:0]                  rbb_req_ack,
    input  logic [NUM_RBB*HOST_ADDR_WIDTH-1:0]  rbb_base_addr,
    output logic                                wr_req_valid,
    output logic [HOST_ADDR_WIDTH-1:0]          wr_req_addr,
    output logic [RBB_DATA_WIDTH-1:0]           wr_req_data,
    input  logic                                wr_req_almfull,
    output logic [NUM_RBB-1:0]                  batch_done,
    output logic                                busy,
`ifdef RBB_ARB_STATS_EN
    output logic [NUM_RBB*32-1:0]               batch_cnt,
    output logic [31:0]                         stall_cnt,
`endif
    output logic                                err_drop
);

    localparam int IDX_W = (NUM_RBB > 1) ? $clog2(NUM_RBB) : 1;
    localparam int CNT_W = RBB_ADDR_WIDTH + LINE_CNT_EXTRA;
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(numLines(RBB_ADDR_WIDTH) - 1);

    arbState_t                 state;
    logic [IDX_W-1:0]          grant;
    logic [IDX_W-1:0]          rrPtr;
    logic [IDX_W-1:0]          pickIdx;
    logic                      pickFound;
    logic [CNT_W-1:0]          lineCnt;
    logic                      grantVld;
    logic                      issueOk;
    logic [RBB_ADDR_WIDTH-1:0] grantLine;

    rr_pick #(.N(NUM_RBB), .IW(IDX_W)) u_pick (
        .req   (rbb_req_valid),
        .ptr   (rrPtr),
        .idx   (pickIdx),
        .found (pickFound)
    );

    assign grantVld  = rbb_req_valid[grant];
    assign grantLine = rbb_req_line_idx[grant*RBB_ADDR_WIDTH +: RBB_ADDR_WIDTH];
    assign issueOk   = (state == ISSUE) && grantVld && !wr_req_almfull;
    assign busy      = (state != IDLE);

    always_comb begin
        rbb_req_ack = '0;
        if (issueOk) rbb_req_ack[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= '0;
            rrPtr        <= '0;
            lineCnt      <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_data  <= '0;
            batch_done   <= '0;
            err_drop     <= 1'b0;
        end else begin
            wr_req_valid <= 1'b0;
            batch_done   <= '0;
            case (state)
                IDLE: begin
                    if (pickFound) begin
                        grant   <= pickIdx;
                        lineCnt <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!grantVld) begin
                        err_drop <= 1'b1;
                        rrPtr    <= grant;
                        state    <= IDLE;
                    end else if (!wr_req_almfull) begin
                        wr_req_valid <= 1'b1;
                        wr_req_addr  <= rbb_base_addr[grant*HOST_ADDR_WIDTH +: HOST_ADDR_WIDTH]
                                        + HOST_ADDR_WIDTH'(grantLine);
                        wr_req_data  <= rbb_rd_dout[grant*RBB_DATA_WIDTH +: RBB_DATA_WIDTH];
                        lineCnt      <= lineCnt + CNT_W'(1);
                        if (lineCnt == LAST_LINE) begin
                            batch_done[grant] <= 1'b1;
                            rrPtr             <= grant;
                            state             <= IDLE;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                // Bubble lets the buffer's registered read present the next line.
                SETTLE: begin
                    if (!grantVld) begin
                        err_drop <= 1'b1;
                        rrPtr    <= grant;
                        state    <= IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RBB_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            batch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_RBB; i++) begin
                if (batch_done[i]) batch_cnt[i*32 +: 32] <= batch_cnt[i*32 +: 32] + 32'd1;
            end
            if ((state == ISSUE) && grantVld && wr_req_almfull) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rbb_wr_arbiter.sv
// Bench for rbb_wr_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_rbb_wr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 2;
    localparam int DW  = 64;
    localparam int HAW = 32;
    localparam int NL  = 1 << AW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      rbb_req_valid;
    logic [N*AW-1:0]   rbb_req_line_idx;
    logic [N*DW-1:0]   rbb_rd_dout;
    logic [N-1:0]      rbb_req_ack;
    logic [N*HAW-1:0]  rbb_base_addr;
    logic              wr_req_valid;
    logic [HAW-1:0]    wr_req_addr;
    logic [DW-1:0]     wr_req_data;
    logic              wr_req_almfull;
    logic [N-1:0]      batch_done;
    logic              busy;
    logic              err_drop;
`ifdef RBB_ARB_STATS_EN
    logic [N*32-1:0]   batch_cnt;
    logic [31:0]       stall_cnt;
`endif

    rbb_wr_arbiter #(
        .NUM_RBB(N), .RBB_ADDR_WIDTH(AW), .RBB_DATA_WIDTH(DW), .HOST_ADDR_WIDTH(HAW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rbb_req_valid    (rbb_req_valid),
        .rbb_req_line_idx (rbb_req_line_idx),
        .rbb_rd_dout      (rbb_rd_dout),
        .rbb_req_ack      (rbb_req_ack),
        .rbb_base_addr    (rbb_base_addr),
        .wr_req_valid     (wr_req_valid),
        .wr_req_addr      (wr_req_addr),
        .wr_req_data      (wr_req_data),
        .wr_req_almfull   (wr_req_almfull),
        .batch_done       (batch_done),
        .busy             (busy),
`ifdef RBB_ARB_STATS_EN
        .batch_cnt        (batch_cnt),
        .stall_cnt        (stall_cnt),
`endif
        .err_drop         (err_drop)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Buffer-side stimulus state
    bit          bufActive[N];
    bit          bufHide[N];
    bit          drvValid[N];
    int          bufIdx[N];
    int          bufSeq[N];
    logic [31:0] bufBase[N];
    bit          almfull;
    bit          randomMode;

    // Reference model
    int          mSt;      // 0 idle, 1 issuing, 2 bubble
    int          mRr;
    int          mOwner;
    int          mCnt;
    bit          mErr;
    bit          expVld;
    logic [31:0] expAddr;
    logic [63:0] expData;
    logic [N-1:0] expDone;
    bit          expBusy;
    bit          ackPrev;
    int          cycle;

    logic [31:0] addrLog[$];
    int          doneLog[$];
    int          ackCycles[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic timeoutFail(input string name);
        nTests++;
        nFail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    function automatic logic [63:0] dataOf(input int i, input int seq, input int idx);
        return {8'(i), 24'(seq), 32'(idx) ^ 32'hDEAD0000};
    endfunction

    task automatic modelReset();
        mSt = 0; mRr = 0; mOwner = 0; mCnt = 0; mErr = 0;
        expVld = 0; expAddr = '0; expData = '0; expDone = '0; expBusy = 0; ackPrev = 0;
        for (int i = 0; i < N; i++) bufIdx[i] = 0;
    endtask

    task automatic clearLogs();
        addrLog.delete(); doneLog.delete(); ackCycles.delete();
    endtask

    task automatic step();
        logic [N-1:0] expAck;
        int pick;
        bit owned;
        @(negedge clk);
        cycle++;
        chk("wr_req_valid", wr_req_valid, expVld);
        if (expVld) begin
            chk("wr_req_addr", wr_req_addr, expAddr);
            chk("wr_req_data", wr_req_data, expData);
        end
        chk("batch_done", batch_done, expDone);
        chk("busy", busy, expBusy);
        chk("err_drop", err_drop, mErr);
        if (wr_req_valid) addrLog.push_back(wr_req_addr);
        for (int i = 0; i < N; i++) if (batch_done[i]) doneLog.push_back(i);

        if (randomMode) begin
            for (int i = 0; i < N; i++) begin
                owned = (mSt != 0) && (mOwner == i);
                if (!bufActive[i] && ($urandom % 6 == 0)) begin
                    bufActive[i] = 1;
                    bufIdx[i]    = 0;
                    bufBase[i]   = ($urandom % 4 == 0) ? (32'hFFFFFFFF - 32'($urandom % 3)) : 32'($urandom);
                end
                bufHide[i] = !owned && (bufIdx[i] == 0) && ($urandom % 4 == 0);
                if (owned && bufActive[i] && ($urandom % 300 == 0)) begin
                    bufActive[i] = 0; bufIdx[i] = 0; bufSeq[i]++;
                end
            end
            almfull = ($urandom % 4 == 0);
        end

        for (int i = 0; i < N; i++) begin
            drvValid[i] = bufActive[i] && !bufHide[i];
            rbb_req_valid[i]             = drvValid[i];
            rbb_req_line_idx[i*AW +: AW] = AW'(bufIdx[i]);
            rbb_rd_dout[i*DW +: DW]      = dataOf(i, bufSeq[i], bufIdx[i]);
            rbb_base_addr[i*HAW +: HAW]  = bufBase[i];
        end
        wr_req_almfull = almfull;
        #1;

        expAck = '0;
        if (mSt == 1 && drvValid[mOwner] && !almfull) expAck[mOwner] = 1'b1;
        chk("rbb_req_ack", rbb_req_ack, expAck);
        if (ackPrev) chk("ack_gap", 64'(rbb_req_ack != 0), 64'd0);
        ackPrev = (rbb_req_ack != 0);
        if (rbb_req_ack != 0) ackCycles.push_back(cycle);

        expVld  = 0;
        expDone = '0;
        case (mSt)
            0: begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && drvValid[(mRr + k) % N]) pick = (mRr + k) % N;
                if (pick >= 0) begin
                    mOwner = pick; mCnt = 0; mSt = 1;
                end
            end
            1: begin
                if (!drvValid[mOwner]) begin
                    mErr = 1; mRr = mOwner; mSt = 0;
                end else if (!almfull) begin
                    expVld  = 1;
                    expAddr = bufBase[mOwner] + 32'(bufIdx[mOwner]);
                    expData = dataOf(mOwner, bufSeq[mOwner], bufIdx[mOwner]);
                    mCnt++;
                    bufIdx[mOwner]++;
                    if (bufIdx[mOwner] == NL) begin
                        bufActive[mOwner] = 0; bufIdx[mOwner] = 0; bufSeq[mOwner]++;
                    end
                    if (mCnt == NL) begin
                        expDone[mOwner] = 1'b1; mRr = mOwner; mSt = 0;
                    end else begin
                        mSt = 2;
                    end
                end
            end
            default: begin
                if (!drvValid[mOwner]) begin
                    mErr = 1; mRr = mOwner; mSt = 0;
                end else begin
                    mSt = 1;
                end
            end
        endcase
        expBusy = (mSt != 0);
    endtask

    task automatic waitDone(input int n, input int budget, input string name);
        int b = 0;
        while (doneLog.size() < n && b < budget) begin step(); b++; end
        if (doneLog.size() < n) timeoutFail(name);
    endtask

    task automatic waitAddrs(input int n, input int budget, input string name);
        int b = 0;
        while (addrLog.size() < n && b < budget) begin step(); b++; end
        if (addrLog.size() < n) timeoutFail(name);
    endtask

    task automatic checkAddrs(input string name, input logic [31:0] base, input int first);
        logic [31:0] e;
        for (int k = 0; k < NL; k++) begin
            e = base + 32'(k);
            if (addrLog.size() > first + k) chk(name, addrLog[first + k], e);
            else timeoutFail(name);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_ack"}, rbb_req_ack, 0);
        chk({tag, "_wr_valid"}, wr_req_valid, 0);
        chk({tag, "_wr_addr"}, wr_req_addr, 0);
        chk({tag, "_wr_data"}, wr_req_data, 0);
        chk({tag, "_batch_done"}, batch_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_drop"}, err_drop, 0);
`ifdef RBB_ARB_STATS_EN
        chk({tag, "_batch_cnt"}, 64'(batch_cnt), 0);
`endif
    endtask

    initial begin
        logic [31:0] wrapAddr[4];
        int order[4];
        cycle = 0;
        randomMode = 0; almfull = 0;
        for (int i = 0; i < N; i++) begin
            bufActive[i] = 0; bufHide[i] = 0; bufSeq[i] = 0; bufBase[i] = '0; drvValid[i] = 0;
        end
        reset_n = 1'b0;
        rbb_req_valid = '0; rbb_req_line_idx = '0; rbb_rd_dout = '0; rbb_base_addr = '0;
        wr_req_almfull = 1'b0;
        modelReset();
        #1;
        checkResetOutputs("reset");
        #21 reset_n = 1'b1;

        // Single requester, four lines from 0x100, acks two cycles apart
        clearLogs();
        bufActive[1] = 1; bufBase[1] = 32'h100;
        waitDone(1, 40, "t1_done");
        repeat (2) step();
        chk("t1_nlines", addrLog.size(), 4);
        checkAddrs("t1_addr", 32'h100, 0);
        chk("t1_done_cnt", doneLog.size(), 1);
        if (doneLog.size() > 0) chk("t1_done_idx", doneLog[0], 1);
        for (int k = 1; k < ackCycles.size(); k++)
            chk("t1_ack_spacing", ackCycles[k] - ackCycles[k-1], 2);

        // Host address wraps past 2^32
        clearLogs();
        bufActive[0] = 1; bufBase[0] = 32'hFFFFFFFE;
        waitDone(1, 40, "t5_done");
        repeat (2) step();
        wrapAddr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        for (int k = 0; k < 4; k++)
            if (addrLog.size() > k) chk("t5_wrap_addr", addrLog[k], wrapAddr[k]);
            else timeoutFail("t5_wrap_addr");

        // All four request together with rr_ptr at 0: order 1,2,3,0, batches contiguous
        clearLogs();
        for (int i = 0; i < N; i++) begin bufActive[i] = 1; bufBase[i] = 32'h1000 * (i + 1); end
        waitDone(4, 200, "t2_done");
        repeat (2) step();
        order = '{1, 2, 3, 0};
        for (int b = 0; b < 4; b++) begin
            if (doneLog.size() > b) chk("t2_order", doneLog[b], order[b]);
            checkAddrs("t2_contig", 32'h1000 * (order[b] + 1), b * NL);
        end

        // almfull held five cycles mid-batch: nothing issued, resumes at the same line
        clearLogs();
        bufActive[2] = 1; bufBase[2] = 32'h200;
        waitAddrs(1, 20, "t3_first");
        almfull = 1;
        repeat (5) step();
        chk("t3_held", addrLog.size(), 1);
        almfull = 0;
        waitDone(1, 40, "t3_done");
        repeat (2) step();
        checkAddrs("t3_addr", 32'h200, 0);

        // Granted buffer drops valid after two lines
        clearLogs();
        bufActive[3] = 1; bufBase[3] = 32'h300;
        waitAddrs(2, 20, "t4_two");
        bufActive[3] = 0; bufIdx[3] = 0; bufSeq[3]++;
        repeat (2) step();
        chk("t4_err_drop", err_drop, 1);
        chk("t4_busy", busy, 0);
        chk("t4_no_done", doneLog.size(), 0);

        // Reset mid-batch, then the partially drained buffer starts over
        clearLogs();
        bufActive[1] = 1; bufBase[1] = 32'h400;
        waitAddrs(2, 20, "t6_two");
        #2 reset_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        rbb_req_valid = '0;
        modelReset();
        clearLogs();
        @(posedge clk);
        #2 reset_n = 1'b1;
        waitDone(1, 40, "t6_done");
        repeat (2) step();
        checkAddrs("t6_restart_addr", 32'h400, 0);

        // Random traffic against the model
        randomMode = 1;
        repeat (3000) step();
        randomMode = 0;
        almfull = 0;
        for (int i = 0; i < N; i++) begin bufActive[i] = 0; bufHide[i] = 0; end
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
